// File: rtl/ip_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ip_pkg : framing constants and tx FSM states shared by IPv4 tx/rx paths  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ip_pkg;

  localparam int          ETH_HDR_SIZE_BYTES    = 14;
  localparam int          IP_HDR_SIZE_BYTES     = 20;
  localparam int          MIN_ETH_PAYLOAD_BYTES = 46;
  localparam int          IP_HDR_WORDS          = IP_HDR_SIZE_BYTES / 2;
  localparam logic [15:0] ETHERTYPE_IPV4        = 16'h0800;
  localparam logic [15:0] IPV4_VER_IHL_TOS      = 16'h4500;
  localparam logic [15:0] IPV4_FLAGS_DF         = 16'h4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSUM = 2'd1,
    SEND = 2'd2
  } tx_state_t;

  // Short IP datagrams are zero-padded up to the Ethernet minimum payload.
  function automatic int frame_len(input int payload_bytes);
    int ip_len;
    ip_len = IP_HDR_SIZE_BYTES + payload_bytes;
    return ETH_HDR_SIZE_BYTES +
           ((ip_len > MIN_ETH_PAYLOAD_BYTES) ? ip_len : MIN_ETH_PAYLOAD_BYTES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_checksum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ip_checksum : one's-complement sum of 16-bit words, one word per cycle   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ip_checksum (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  output logic [15:0] csum_o
);

  logic [31:0] acc_q, acc_d;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {16'h0000, word_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // After the first fold a carry can only occur when the low half is <= FFFE,
  // so the second fold never overflows 16 bits.
  assign w_fold1 = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
  assign w_fold2 = w_fold1[15:0] + {15'h0000, w_fold1[16]};
  assign csum_o  = ~w_fold2;

endmodule
`default_nettype wire

// File: rtl/ip_packet_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ip_packet_tx : builds Eth II + IPv4 frame around one payload, 8-bit AXI-S|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ip_packet_tx
  import ip_pkg::*;
#(
  parameter int         IP_ADDR_WIDTH    = 32,
  parameter int         MAC_ADDR_WIDTH   = 48,
  parameter int         AXI_S_DATA_WIDTH = 8,
  parameter int         PAYLOAD_BYTES    = 4,
  parameter logic [7:0] IP_PROTOCOL      = 8'hFD,
  parameter logic [7:0] IP_TTL           = 8'h40
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [IP_ADDR_WIDTH-1:0]      ACCELERATOR_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]     ACCELERATOR_MAC_ADDRESS,
  input  logic [IP_ADDR_WIDTH-1:0]      DST_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]     DST_MAC_ADDRESS,
  input  logic [PAYLOAD_BYTES*8-1:0]    DATA_FRAME,
  input  logic                          FRAME_VALID,
  output logic                          FRAME_READY,
  output logic [AXI_S_DATA_WIDTH-1:0]   MAC_DATA_IN,
  output logic                          MAC_DATA_VALID,
  input  logic                          MAC_DATA_READY,
  output logic                          MAC_DATA_LAST,
  output logic                          MAC_DATA_TUSER
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CSUM = CSUM;
  localparam logic [1:0] S_SEND = SEND;

  localparam int FRAME_LEN = frame_len(PAYLOAD_BYTES);
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam int MAC_BYTES = MAC_ADDR_WIDTH / 8;
  localparam int MAC_SEL_W = $clog2(MAC_BYTES);
  localparam int PAY_SEL_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  localparam logic [IDX_W-1:0] C_SRC_MAC = IDX_W'(MAC_BYTES);
  localparam logic [IDX_W-1:0] C_ETYPE   = IDX_W'(2 * MAC_BYTES);
  localparam logic [IDX_W-1:0] C_IP      = IDX_W'(ETH_HDR_SIZE_BYTES);
  localparam logic [IDX_W-1:0] C_PAY     = IDX_W'(ETH_HDR_SIZE_BYTES + IP_HDR_SIZE_BYTES);
  localparam logic [IDX_W-1:0] C_PAD     = IDX_W'(ETH_HDR_SIZE_BYTES + IP_HDR_SIZE_BYTES + PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(FRAME_LEN - 1);
  localparam logic [15:0]      C_TOT_LEN = 16'(IP_HDR_SIZE_BYTES + PAYLOAD_BYTES);
  localparam logic [3:0]       C_LAST_WD = 4'(IP_HDR_WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ready_q;
  logic [15:0]      id_q, id_d;

  logic [IP_ADDR_WIDTH-1:0]   src_ip_q, dst_ip_q;
  logic [MAC_ADDR_WIDTH-1:0]  src_mac_q, dst_mac_q;
  logic [PAYLOAD_BYTES*8-1:0] payload_q;
  logic [15:0]                id_frame_q;

  logic                 w_accept;
  logic                 w_csum_add;
  logic [15:0]          w_csum;
  logic [15:0]          w_hdr_word;
  logic [3:0]           w_word_sel;
  logic [4:0]           w_hdr_off;
  logic [MAC_SEL_W-1:0] w_dmac_sel, w_smac_sel;
  logic [PAY_SEL_W-1:0] w_pay_sel;
  logic [7:0]           w_byte;
  logic [7:0]           w_dmac_bytes [MAC_BYTES];
  logic [7:0]           w_smac_bytes [MAC_BYTES];
  logic [7:0]           w_pay_bytes  [PAYLOAD_BYTES];

  assign w_accept = FRAME_VALID & ready_q;

  for (genvar k = 0; k < MAC_BYTES; k++) begin : g_mac_bytes
    assign w_dmac_bytes[k] = dst_mac_q[MAC_ADDR_WIDTH-1-8*k -: 8];
    assign w_smac_bytes[k] = src_mac_q[MAC_ADDR_WIDTH-1-8*k -: 8];
  end

  for (genvar k = 0; k < PAYLOAD_BYTES; k++) begin : g_pay_bytes
    assign w_pay_bytes[k] = payload_q[8*k +: 8];
  end

  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      src_ip_q   <= ACCELERATOR_IP_ADDRESS;
      src_mac_q  <= ACCELERATOR_MAC_ADDRESS;
      dst_ip_q   <= DST_IP_ADDRESS;
      dst_mac_q  <= DST_MAC_ADDRESS;
      payload_q  <= DATA_FRAME;
      id_frame_q <= id_q;
    end
  end

  // The same word mux feeds the checksum during CSUM and the byte stream in SEND.
  always_comb begin
    w_word_sel = (state_q == S_CSUM) ? cnt_q : w_hdr_off[4:1];
    case (w_word_sel)
      4'd0:    w_hdr_word = IPV4_VER_IHL_TOS;
      4'd1:    w_hdr_word = C_TOT_LEN;
      4'd2:    w_hdr_word = id_frame_q;
      4'd3:    w_hdr_word = IPV4_FLAGS_DF;
      4'd4:    w_hdr_word = {IP_TTL, IP_PROTOCOL};
      4'd5:    w_hdr_word = (state_q == S_CSUM) ? 16'h0000 : w_csum;
      4'd6:    w_hdr_word = src_ip_q[IP_ADDR_WIDTH-1 -: 16];
      4'd7:    w_hdr_word = src_ip_q[15:0];
      4'd8:    w_hdr_word = dst_ip_q[IP_ADDR_WIDTH-1 -: 16];
      4'd9:    w_hdr_word = dst_ip_q[15:0];
      default: w_hdr_word = 16'h0000;
    endcase
  end

  always_comb begin
    w_hdr_off  = 5'(idx_q - C_IP);
    w_dmac_sel = MAC_SEL_W'(idx_q);
    w_smac_sel = MAC_SEL_W'(idx_q - C_SRC_MAC);
    w_pay_sel  = PAY_SEL_W'(idx_q - C_PAY);
    if (idx_q < C_SRC_MAC) begin
      w_byte = w_dmac_bytes[w_dmac_sel];
    end else if (idx_q < C_ETYPE) begin
      w_byte = w_smac_bytes[w_smac_sel];
    end else if (idx_q == C_ETYPE) begin
      w_byte = ETHERTYPE_IPV4[15:8];
    end else if (idx_q < C_IP) begin
      w_byte = ETHERTYPE_IPV4[7:0];
    end else if (idx_q < C_PAY) begin
      w_byte = w_hdr_off[0] ? w_hdr_word[7:0] : w_hdr_word[15:8];
    end else if (idx_q < C_PAD) begin
      w_byte = w_pay_bytes[w_pay_sel];
    end else begin
      w_byte = 8'h00;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    id_d       = id_q;
    w_csum_add = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          id_d    = id_q + 16'd1;
          cnt_d   = 4'd0;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        w_csum_add = 1'b1;
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == C_LAST_WD) begin
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Output register refills when empty or when its byte is being taken.
        if (!valid_q || MAC_DATA_READY) begin
          if (valid_q && last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            data_d  = w_byte;
            valid_d = 1'b1;
            last_d  = (idx_q == C_LAST);
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= (state_d == S_IDLE);
      id_q    <= id_d;
    end
  end

  ip_checksum u_checksum (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .clear_i (w_accept),
    .add_i   (w_csum_add),
    .word_i  (w_hdr_word),
    .csum_o  (w_csum)
  );

  assign FRAME_READY    = ready_q;
  assign MAC_DATA_IN    = data_q;
  assign MAC_DATA_VALID = valid_q;
  assign MAC_DATA_LAST  = last_q;
  assign MAC_DATA_TUSER = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ip_packet_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ip_packet_tx : directed + randomized frames against a frame model     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ip_packet_tx;

  logic         ACLK    = 1'b0;
  logic         ARESETN = 1'b0;
  logic [31:0]  src_ip, dst_ip;
  logic [47:0]  src_mac, dst_mac;
  logic [31:0]  data4;
  logic [319:0] data40;
  logic         fv4, fv40, mac_ready;
  logic         fr4, fr40, mv4, mv40, ml4, ml40, mu4, mu40;
  logic [7:0]   md4, md40;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [15:0] id4  = 16'h0000;
  logic [15:0] id40 = 16'h0000;

  always #5 ACLK = ~ACLK;

  ip_packet_tx #(.PAYLOAD_BYTES(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
    .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
    .DATA_FRAME(data4), .FRAME_VALID(fv4), .FRAME_READY(fr4),
    .MAC_DATA_IN(md4), .MAC_DATA_VALID(mv4), .MAC_DATA_READY(mac_ready),
    .MAC_DATA_LAST(ml4), .MAC_DATA_TUSER(mu4)
  );

  ip_packet_tx #(.PAYLOAD_BYTES(40)) dut40 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
    .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
    .DATA_FRAME(data40), .FRAME_VALID(fv40), .FRAME_READY(fr40),
    .MAC_DATA_IN(md40), .MAC_DATA_VALID(mv40), .MAC_DATA_READY(mac_ready),
    .MAC_DATA_LAST(ml40), .MAC_DATA_TUSER(mu40)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void get(input bit big, output logic [7:0] d,
                              output logic v, output logic l, output logic r, output logic u);
    if (big) begin d = md40; v = mv40; l = ml40; r = fr40; u = mu40; end
    else     begin d = md4;  v = mv4;  l = ml4;  r = fr4;  u = mu4;  end
  endfunction

  // Reference frame: Ethernet II + IPv4 header, one's-complement checksum, zero pad.
  function automatic void build_frame(input logic [47:0] dmac, input logic [47:0] smac,
                                      input logic [31:0] sip, input logic [31:0] dip,
                                      input logic [319:0] pay, input int plen,
                                      input logic [15:0] id, output logic [7:0] fr[$]);
    int          iplen, flen;
    int unsigned s;
    logic [15:0] w [10];
    iplen = 20 + plen;
    flen  = 14 + ((iplen < 46) ? 46 : iplen);
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(dmac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(smac[8*(5-i) +: 8]);
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    w = '{16'h4500, 16'(iplen), id, 16'h4000, 16'h40FD, 16'h0000,
          sip[31:16], sip[15:0], dip[31:16], dip[15:0]};
    s = 0;
    for (int i = 0; i < 10; i++) s += w[i];
    while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
    w[5] = 16'(~s);
    for (int i = 0; i < 10; i++) begin
      fr.push_back(w[i][15:8]);
      fr.push_back(w[i][7:0]);
    end
    for (int k = 0; k < plen; k++) fr.push_back(pay[8*k +: 8]);
    while (fr.size() < flen) fr.push_back(8'h00);
  endfunction

  task automatic do_frame(input bit big, input logic [31:0] sip, input logic [31:0] dip,
                          input logic [47:0] smac, input logic [47:0] dmac,
                          input logic [319:0] pay, input bit rnd, input bit pulse,
                          input int abort_at, input string tag,
                          output logic [7:0] got[$], output bit aborted);
    logic [7:0] exp[$];
    logic [7:0] d, pd;
    logic       v, l, r, u, pv, pl;
    bit         stall, done, fv;
    int         n, first_n;
    if (big) begin build_frame(dmac, smac, sip, dip, pay, 40, id40, exp); id40++; end
    else     begin build_frame(dmac, smac, sip, dip, pay, 4,  id4,  exp); id4++;  end
    got = {};
    aborted = 1'b0;
    @(negedge ACLK);
    get(big, d, v, l, r, u);
    chk({tag, " ready before accept"}, r, 1);
    src_ip = sip; dst_ip = dip; src_mac = smac; dst_mac = dmac;
    if (big) begin data40 = pay; fv40 = 1'b1; end
    else     begin data4 = pay[31:0]; fv4 = 1'b1; end
    @(posedge ACLK);
    @(negedge ACLK);
    fv4 = 1'b0; fv40 = 1'b0;
    src_ip = $urandom(); dst_ip = $urandom();
    src_mac = 48'({$urandom(), $urandom()}); dst_mac = 48'({$urandom(), $urandom()});
    data4 = $urandom();
    for (int i = 0; i < 10; i++) data40[32*i +: 32] = $urandom();
    n = 0; first_n = 0; stall = 1'b0; done = 1'b0;
    pd = '0; pv = 1'b0; pl = 1'b0;
    while (!done && n < 3000) begin
      @(negedge ACLK);
      n++;
      get(big, d, v, l, r, u);
      if (stall) chk({tag, " hold while stalled"}, {d, v, l}, {pd, pv, pl});
      if (v && first_n == 0) begin
        first_n = n;
        chk({tag, " first valid latency"}, n, 11);
        chk({tag, " tuser"}, u, 0);
      end
      if (abort_at >= 0 && v && got.size() == abort_at) begin
        aborted = 1'b1;
        return;
      end
      mac_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v && mac_ready) begin
        chk($sformatf("%s byte %0d", tag, got.size()), d,
            (got.size() < exp.size()) ? exp[got.size()] : 8'hXX);
        chk($sformatf("%s last at %0d", tag, got.size()), l, (got.size() == exp.size() - 1));
        got.push_back(d);
        if (l) done = 1'b1;
      end
      stall = v && !mac_ready;
      pd = d; pv = v; pl = l;
      if (pulse) begin
        fv = !l && ($urandom_range(0, 1) == 1);
        if (big) fv40 = fv; else fv4 = fv;
        if (fv) chk({tag, " ready low while busy"}, r, 0);
      end
    end
    fv4 = 1'b0; fv40 = 1'b0;
    chk({tag, " frame length"}, got.size(), exp.size());
    @(negedge ACLK);
    get(big, d, v, l, r, u);
    chk({tag, " ready after last"}, r, 1);
    chk({tag, " valid after last"}, v, 0);
    mac_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  SIP, DIP;
    logic [47:0]  SMAC, DMAC;
    logic [319:0] pay, rpay;
    logic [159:0] hdr1;
    logic [7:0]   got[$];
    bit           ab;

    SIP  = 32'hC0A8010A; DIP  = 32'hC0A80101;
    SMAC = 48'h020000000001; DMAC = 48'h020000000002;
    pay  = '0; pay[31:0] = 32'hEFBEADDE;
    hdr1 = 160'h450000180000400040FDB68DC0A8010AC0A80101;
    src_ip = '0; dst_ip = '0; src_mac = '0; dst_mac = '0;
    data4 = '0; data40 = '0; fv4 = 1'b0; fv40 = 1'b0; mac_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset valid", mv4, 0);
    chk("reset last", ml4, 0);
    chk("reset data", md4, 0);
    chk("reset ready", fr4, 0);
    chk("reset ready 40", fr40, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("ready after release", fr4, 1);
    chk("ready after release 40", fr40, 1);

    // 1: first frame, fixed header bytes
    do_frame(0, SIP, DIP, SMAC, DMAC, pay, 0, 0, -1, "t1", got, ab);
    chk("t1 size", got.size(), 60);
    for (int i = 0; i < 20; i++)
      chk($sformatf("t1 ip hdr %0d", i), got[14+i], hdr1[159-8*i -: 8]);
    chk("t1 payload", {got[34], got[35], got[36], got[37]}, 32'hDEADBEEF);
    chk("t1 pad", {got[38], got[59]}, 16'h0000);

    // 2: second frame, ID and checksum advance
    do_frame(0, SIP, DIP, SMAC, DMAC, pay, 0, 0, -1, "t2", got, ab);
    chk("t2 id", {got[18], got[19]}, 16'h0001);
    chk("t2 checksum", {got[24], got[25]}, 16'hB68C);

    // 3: random READY back-pressure
    do_frame(0, SIP, DIP, SMAC, DMAC, pay, 1, 0, -1, "t3", got, ab);

    // 4: 40-byte payload, no padding
    rpay = '0;
    for (int i = 0; i < 10; i++) rpay[32*i +: 32] = $urandom();
    do_frame(1, SIP, DIP, SMAC, DMAC, rpay, 0, 0, -1, "t4", got, ab);
    chk("t4 size", got.size(), 74);
    chk("t4 total length", {got[16], got[17]}, 16'h003C);

    // 5: reset in the middle of a frame
    do_frame(0, SIP, DIP, SMAC, DMAC, pay, 0, 0, 20, "t5", got, ab);
    chk("t5 reached byte 20", ab, 1);
    ARESETN = 1'b0;
    id4 = 16'h0000; id40 = 16'h0000;
    @(negedge ACLK);
    chk("t5 valid in reset", mv4, 0);
    chk("t5 last in reset", ml4, 0);
    chk("t5 ready in reset", fr4, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("t5 ready after release", fr4, 1);
    do_frame(0, SIP, DIP, SMAC, DMAC, pay, 0, 0, -1, "t5b", got, ab);
    chk("t5b id", {got[18], got[19]}, 16'h0000);
    chk("t5b checksum", {got[24], got[25]}, 16'hB68D);

    // 6: ID wrap, FRAME_VALID pulsed while busy
    @(negedge ACLK);
    force dut.id_q = 16'hFFFF;
    @(negedge ACLK);
    release dut.id_q;
    id4 = 16'hFFFF;
    do_frame(0, SIP, DIP, SMAC, DMAC, pay, 0, 1, -1, "t6", got, ab);
    chk("t6 id", {got[18], got[19]}, 16'hFFFF);
    do_frame(0, SIP, DIP, SMAC, DMAC, pay, 1, 1, -1, "t6b", got, ab);
    chk("t6b id", {got[18], got[19]}, 16'h0000);

    // Randomized addresses, payloads and back-pressure
    for (int f = 0; f < 3; f++) begin
      rpay = '0;
      rpay[31:0] = $urandom();
      do_frame(0, $urandom(), $urandom(), 48'({$urandom(), $urandom()}),
               48'({$urandom(), $urandom()}), rpay, 1, 1, -1,
               $sformatf("rnd%0d", f), got, ab);
    end
    for (int i = 0; i < 10; i++) rpay[32*i +: 32] = $urandom();
    do_frame(1, $urandom(), $urandom(), 48'({$urandom(), $urandom()}),
             48'({$urandom(), $urandom()}), rpay, 1, 1, -1, "rnd40", got, ab);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
